// File: rtl/clk_div_prog.sv
// Programmable clock divider with a 50% duty output for every ratio from 2 to 15.
// Ratio changes are taken through a one-deep pending register and applied only at period boundaries.
`timescale 1ns/1ps

module clk_div_prog #(
   parameter int unsigned DEFAULT_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       cfg_valid,
   input  logic [3:0] cfg_div,
   output logic       cfg_ready,
   output logic       cfg_err,
   output logic       clk_out,
   output logic       tick,
   output logic       running
);

   localparam logic [3:0] DIV_RST = 4'(DEFAULT_DIV);

   logic [3:0] div_act;
   logic [3:0] div_pend;
   logic       pend_vld;
   logic [3:0] cnt;
   logic       pos_q;
   logic       neg_q;

   logic       cfg_hs;
   logic       cfg_legal;
   logic       wrap;
   logic       apply;
   logic [3:0] div_nxt;
   logic [3:0] cnt_nxt;
   logic       run_nxt;

   // Next-state view of the counter; pos_q and tick are computed from it so they
   // line up with the edge that starts each period instead of lagging by a cycle.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      run_nxt   = running;
      cnt_nxt   = cnt;
      cfg_hs    = cfg_valid & ~pend_vld;
      cfg_legal = (cfg_div >= 4'd2);
      wrap      = running && (cnt == (div_act - 4'd1));
      apply     = pend_vld && (wrap || !running);
      div_nxt   = apply ? div_pend : div_act;

      if (running) begin
         if (wrap) begin
            cnt_nxt = 4'd0;
            run_nxt = enable;
         end else begin
            cnt_nxt = cnt + 4'd1;
         end
      end else if (enable) begin
         run_nxt = 1'b1;
         cnt_nxt = 4'd0;
      end
   end

   // NOTE: asynchronous active-low reset; state registers use non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_act  <= DIV_RST;
         div_pend <= DIV_RST;
         pend_vld <= 1'b0;
         cnt      <= 4'd0;
         running  <= 1'b0;
         pos_q    <= 1'b0;
         tick     <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         div_act <= div_nxt;
         cnt     <= cnt_nxt;
         running <= run_nxt;

         // apply and a new handshake are mutually exclusive: one needs pend_vld set, the other clear
         if (apply) begin
            pend_vld <= 1'b0;
         end else if (cfg_hs && cfg_legal) begin
            pend_vld <= 1'b1;
            div_pend <= cfg_div;
         end

         cfg_err <= cfg_hs && !cfg_legal;
         pos_q   <= run_nxt && (cnt_nxt < (div_nxt >> 1));
         tick    <= run_nxt && (cnt_nxt == 4'd0);
      end
   end

   // Odd ratios stretch the high phase by half a cycle via a negedge copy of pos_q.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_q <= 1'b0;
      end else begin
         neg_q <= div_act[0] & pos_q;
      end
   end

   assign clk_out   = pos_q | neg_q;
   assign cfg_ready = ~pend_vld;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: stimulus queues expected (high, period) pairs in half-cycles,
// a monitor sampling just after every clk edge measures clk_out and retires them.
`timescale 1ns/1ps

module tb_clk_div_prog;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       cfg_valid = 1'b0;
   logic [3:0] cfg_div = 4'd0;
   logic       cfg_ready;
   logic       cfg_err;
   logic       clk_out;
   logic       tick;
   logic       running;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int high_h;
      int period_h;
   } exp_t;

   exp_t sb[$];

   clk_div_prog #(.DEFAULT_DIV(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .clk_out   (clk_out),
      .tick      (tick),
      .running   (running)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   int   h = 0;
   int   rise_h = 0;
   int   fall_h = 0;
   bit   have_rise = 0;
   logic prev_co = 1'b0;
   logic prev_run = 1'b0;

   task automatic close_period(input int now_h);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_period: got period %0d half-cycles, expected none queued", now_h - rise_h);
      end else begin
         e = sb.pop_front();
         check("clk_out_high_halfcycles", fall_h - rise_h, e.high_h);
         check("clk_out_period_halfcycles", now_h - rise_h, e.period_h);
      end
   endtask

   always @(clk) begin
      bit at_pos;
      bit rose;
      at_pos = (clk == 1'b1);
      #1;
      h++;
      if (!rst_n) begin
         have_rise = 0;
         prev_co   = 1'b0;
         prev_run  = 1'b0;
      end else begin
         rose = clk_out && !prev_co;
         if (rose) begin
            if (have_rise) close_period(h);
            rise_h    = h;
            have_rise = 1;
         end
         if (!clk_out && prev_co) fall_h = h;
         if (!running && prev_run) begin
            if (have_rise) close_period(h);
            have_rise = 0;
            check("clk_out_low_at_stop", int'(clk_out), 0);
         end
         if (at_pos) check("tick_with_clk_out_rise", int'(tick), int'(rose));
         prev_co  = clk_out;
         prev_run = running;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_tick();
      bit seen;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tick) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL tick_timeout: got no tick, expected one within 100 cycles");
      end
   endtask

   task automatic wait_idle();
      bit seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!running) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL stop_timeout: got running=1, expected 0 within 40 cycles");
      end
   endtask

   task automatic push(input int n, input int count);
      exp_t e;
      e.high_h   = n;
      e.period_h = 2 * n;
      for (int i = 0; i < count; i++) sb.push_back(e);
   endtask

   // Runs exactly 'count' periods from parked and parks again.
   task automatic run_phase(input int n, input int count);
      push(n, count);
      enable = 1'b1;
      for (int i = 0; i < count; i++) wait_tick();
      enable = 1'b0;
      wait_idle();
   endtask

   // Loads a legal ratio while parked: pending for one cycle, then applied.
   task automatic config_parked(input int n);
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_div   = 4'(n);
      @(negedge clk);
      cfg_valid = 1'b0;
      check("cfg_ready_low_while_pending", int'(cfg_ready), 0);
      @(negedge clk);
      check("cfg_ready_after_parked_apply", int'(cfg_ready), 1);
   endtask

   task automatic offer_illegal(input int n);
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_div   = 4'(n);
      @(negedge clk);
      cfg_valid = 1'b0;
      check("cfg_err_pulse", int'(cfg_err), 1);
      check("cfg_ready_after_illegal", int'(cfg_ready), 1);
      @(negedge clk);
      check("cfg_err_one_cycle", int'(cfg_err), 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      #3;
      check("reset_clk_out", int'(clk_out), 0);
      check("reset_tick", int'(tick), 0);
      check("reset_running", int'(running), 0);
      check("reset_cfg_ready", int'(cfg_ready), 1);
      check("reset_cfg_err", int'(cfg_err), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // default ratio 4
      run_phase(4, 3);

      // odd ratios and boundaries
      config_parked(3);
      run_phase(3, 3);
      config_parked(5);
      run_phase(5, 3);
      config_parked(2);
      run_phase(2, 3);
      config_parked(15);
      run_phase(15, 2);

      // 4 -> 6 requested mid-period: the current 4-period finishes first
      config_parked(4);
      push(4, 1);
      enable = 1'b1;
      wait_tick();
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_div   = 4'd6;
      @(negedge clk);
      cfg_valid = 1'b0;
      push(6, 2);
      check("cfg_ready_low_after_midperiod_hs", int'(cfg_ready), 0);
      @(negedge clk);
      check("cfg_ready_low_before_wrap", int'(cfg_ready), 0);
      @(negedge clk);
      check("cfg_ready_high_after_wrap", int'(cfg_ready), 1);
      check("tick_at_first_n6_period", int'(tick), 1);
      wait_tick();
      enable = 1'b0;
      wait_idle();

      // illegal ratios leave the active ratio (6) untouched
      offer_illegal(1);
      offer_illegal(0);
      run_phase(6, 2);

      // N=8, drop enable at cnt=1: the period still completes in full
      config_parked(8);
      push(8, 2);
      enable = 1'b1;
      wait_tick();
      wait_tick();
      @(negedge clk);
      enable = 1'b0;
      wait_idle();
      repeat (4) @(negedge clk);
      check("parked_clk_out", int'(clk_out), 0);
      check("parked_running", int'(running), 0);

      // handshake on the wrap edge: captured pending, applied one wrap later
      config_parked(3);
      push(3, 2);
      push(5, 1);
      enable = 1'b1;
      wait_tick();
      @(negedge clk);
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_div   = 4'd5;
      @(negedge clk);
      cfg_valid = 1'b0;
      check("cfg_ready_low_after_wrap_hs", int'(cfg_ready), 0);
      check("tick_at_second_n3_period", int'(tick), 1);
      wait_tick();
      check("cfg_ready_high_after_n5_apply", int'(cfg_ready), 1);
      enable = 1'b0;
      wait_idle();

      // asynchronous reset while clk_out high, with a ratio pending
      config_parked(6);
      enable = 1'b1;
      wait_tick();
      check("clk_out_high_before_reset", int'(clk_out), 1);
      cfg_valid = 1'b1;
      cfg_div   = 4'd9;
      @(negedge clk);
      cfg_valid = 1'b0;
      check("cfg_ready_low_before_reset", int'(cfg_ready), 0);
      #2;
      rst_n  = 1'b0;
      enable = 1'b0;
      #1;
      check("async_reset_clk_out", int'(clk_out), 0);
      check("async_reset_running", int'(running), 0);
      check("async_reset_tick", int'(tick), 0);
      check("async_reset_cfg_ready", int'(cfg_ready), 1);
      check("async_reset_cfg_err", int'(cfg_err), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      // no reconfiguration: the default ratio must be back
      run_phase(4, 2);

      repeat (4) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no completion, expected finish before 200us");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 The block SHALL have parameter DEFAULT_DIV, default 4, meaning the divide ratio loaded at reset (legal range 2..15).
REQ-002 The block SHALL have port clk, input, 1, meaning the single source clock; both edges are used, no other clock exists.
REQ-003 The block SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-004 The block SHALL have port enable, input, 1, meaning run request; sampled on posedge clk.
REQ-005 The block SHALL have port cfg_valid, input, 1, meaning a new divide ratio is offered on cfg_div.
REQ-006 The block SHALL have port cfg_div, input, 4, meaning the requested divide ratio N.
REQ-007 The block SHALL have port cfg_ready, output, 1, meaning the block can accept a new ratio.
REQ-008 The block SHALL have port cfg_err, output, 1, meaning a one-cycle pulse when an illegal ratio is offered.
REQ-009 The block SHALL have port clk_out, output, 1, meaning the divided clock at 50% duty for every legal N.
REQ-010 The block SHALL have port tick, output, 1, meaning a one-clk-cycle clock-enable pulse marking each divided-period start.
REQ-011 The block SHALL have port running, output, 1, meaning the divider is active (not parked).

Function
REQ-012 The block SHALL hold registers div_act (active ratio), div_pend plus pend_vld (pending ratio), cnt (0..div_act-1), pos_q (posedge flop), neg_q (negedge flop), running.
REQ-013 The config handshake SHALL complete on a posedge with cfg_valid=1 and cfg_ready=1; cfg_ready SHALL equal ~pend_vld.
REQ-014 When a handshake carries cfg_div in 2..15, the block SHALL set div_pend=cfg_div and pend_vld=1 at that edge.
REQ-015 When a handshake carries cfg_div of 0 or 1, the block SHALL leave state unchanged and pulse cfg_err high for exactly the next cycle.
REQ-016 When running=1, the block SHALL apply the pending ratio only at wrap: at the posedge where cnt==div_act-1 it SHALL load div_act=div_pend and clear pend_vld.
REQ-017 When running=0 and pend_vld=1, the block SHALL apply the pending ratio on the next posedge.
REQ-018 When parked (running=0) and enable=1 is sampled, the block SHALL set running=1 and cnt=0 at that edge.
REQ-019 When running=1, cnt SHALL increment each posedge and wrap from div_act-1 to 0.
REQ-020 When enable=0 while running, the block SHALL finish the current period and, at the wrap edge, clear running and hold cnt=0; clk_out SHALL have no runt pulse.
REQ-021 For even N, pos_q SHALL be 1 for cnt in 0..N/2-1, neg_q SHALL be held 0, and clk_out SHALL be high N/2 clk cycles and low N/2 cycles.
REQ-022 For odd N, pos_q SHALL be 1 for cnt in 0..(N-1)/2-1, neg_q SHALL be pos_q captured on negedge clk, and clk_out SHALL be high (N/2) cycles and low (N/2) cycles (for N=3, 1.5 high / 1.5 low).
REQ-023 clk_out SHALL equal pos_q OR neg_q, driven only from flops, so it is glitch-free.
REQ-024 While parked, clk_out SHALL be 0.
REQ-025 clk_out SHALL rise on the posedge that starts each period (cnt becomes 0).
REQ-026 tick SHALL be 1 for exactly the cycle in which running=1 and cnt==0, so there is one tick per divided period.
REQ-027 A ratio change SHALL take effect only at a period boundary, and no period SHALL mix two ratios.
REQ-028 When a handshake coincides with the wrap edge while pend_vld=0, the new ratio SHALL be captured as pending and applied at the following wrap.

Reset
REQ-029 On rst_n low, asynchronously: cnt=0, div_act=DEFAULT_DIV, pend_vld=0, pos_q=0, neg_q=0, running=0, clk_out=0, tick=0, cfg_err=0, cfg_ready=1.
REQ-030 On reset mid-period, clk_out SHALL fall immediately.
REQ-031 After rst_n deasserts, the first enable sample SHALL restart from cnt=0.

Verification
REQ-032 Reset then enable=1 with DEFAULT_DIV=4 -> clk_out period 4 clk, 2 high / 2 low, tick every 4th cycle aligned with clk_out rise.
REQ-033 Configure N=3 and N=5, measuring clk_out high time against both clk edges -> 1.5/1.5 and 2.5/2.5 cycles, no glitch.
REQ-034 Change to N=6 mid-period while running at N=4 -> current 4-cycle period completes, then 6-cycle periods; cfg_ready is low until the wrap edge.
REQ-035 Offer cfg_div=1, then cfg_div=0 -> cfg_err pulses 1 cycle each, and ratio and output are unchanged.
REQ-036 Drop enable at cnt=1 of N=8 -> clk_out completes its full low phase, running falls at the wrap, and clk_out stays 0.
REQ-037 Assert rst_n=0 while clk_out is high -> clk_out and all outputs go to reset values without waiting for clk, and div_act returns to DEFAULT_DIV.
